// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - shared rounding mode codes and bias helper
//
// Purpose : Mode code constants and the per-mode bias selection shared by
//           every block that rounds samples.
// Ports   : none (package)
package round_pkg;

   localparam logic [2:0] ROUND_TRUNC     = 3'd0;
   localparam logic [2:0] ROUND_HALF_UP   = 3'd1;
   localparam logic [2:0] ROUND_HALF_DOWN = 3'd2;
   localparam logic [2:0] ROUND_TO_ZERO   = 3'd3;
   localparam logic [2:0] ROUND_FROM_ZERO = 3'd4;
   localparam logic [2:0] ROUND_CONV      = 3'd5;

   // Returns {bit placed just below the kept LSB, bit replicated beneath it}.
   // sign is the sample MSB, lsb is the lowest bit that survives the slice.
   // Codes 6 and 7 fall through to the truncate bias.
   function automatic logic [1:0] round_bias_bits(input logic [2:0] mode,
                                                  input logic       sign,
                                                  input logic       lsb);
      logic [1:0] bits;
      case (mode)
         ROUND_HALF_UP:   bits = 2'b10;
         ROUND_HALF_DOWN: bits = 2'b01;
         ROUND_TO_ZERO:   bits = {sign, ~sign};
         ROUND_FROM_ZERO: bits = {~sign, sign};
         ROUND_CONV:      bits = {lsb, ~lsb};
         default:         bits = 2'b00;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/round_mode.sv
// rtl/round_mode.sv - combinational bias-add and slice rounding datapath
//
// Purpose : Adds the mode-dependent bias to a two's complement sample
//           (wrapping modulo 2^IWID) and keeps the top OWID bits.
// Ports   : sample_i  IWID-bit input sample
//           mode_i    3-bit rounding mode code
//           result_o  OWID-bit rounded result
module round_mode
   import round_pkg::*;
#(
   parameter int IWID = 8,
   parameter int OWID = 5
) (
   input  logic [IWID-1:0] sample_i,
   input  logic [2:0]      mode_i,
   output logic [OWID-1:0] result_o
);

   // Number of discarded bits; at least two so a "below" field always exists.
   localparam int SH = IWID - OWID;

   logic [1:0]      bias_bits;
   logic [IWID-1:0] bias;
   logic [IWID-1:0] sum;
   logic            unused_frac;

   always_comb begin
      bias_bits       = round_bias_bits(mode_i, sample_i[IWID-1], sample_i[SH]);
      bias            = '0;
      bias[SH-1]      = bias_bits[1];
      bias[SH-2:0]    = {(SH-1){bias_bits[0]}};
   end

   // Overflow wraps deliberately: no saturation.
   assign sum         = sample_i + bias;
   assign result_o    = sum[IWID-1:SH];
   assign unused_frac = ^sum[SH-1:0];

endmodule

// File: rtl/round_arbiter.sv
// rtl/round_arbiter.sv - round-robin arbiter feeding a registered rounder
//
// Purpose : Picks one of NCH requesters round-robin, rounds its sample with
//           its own mode and presents the result one cycle later.
// Ports   : i_clk      clock, rising edge
//           i_reset_n  asynchronous active-low reset
//           i_valid    per-channel request valid
//           o_ready    per-channel accept, one-hot or zero
//           i_data     channel k sample in [k*IWID +: IWID]
//           i_mode     channel k mode in [k*3 +: 3]
//           o_valid    result valid
//           i_ready    downstream accept
//           o_data     rounded result
//           o_chan     channel that produced o_data
module round_arbiter
   import round_pkg::*;
#(
   parameter int IWID = 8,
   parameter int OWID = 5,
   parameter int NCH  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [NCH-1:0]          i_valid,
   output logic [NCH-1:0]          o_ready,
   input  logic [NCH*IWID-1:0]     i_data,
   input  logic [NCH*3-1:0]        i_mode,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [OWID-1:0]         o_data,
   output logic [$clog2(NCH)-1:0]  o_chan
);

   localparam int CW = $clog2(NCH);

   logic [CW-1:0]   ptr_q,   ptr_d;
   logic            valid_q, valid_d;
   logic [OWID-1:0] data_q,  data_d;
   logic [CW-1:0]   chan_q,  chan_d;

   logic            can_load;
   logic            grant;
   logic            grant_found;
   logic [CW-1:0]   grant_idx;
   logic [CW-1:0]   scan_idx;
   logic [IWID-1:0] sel_data;
   logic [2:0]      sel_mode;
   logic [OWID-1:0] rounded;

   assign can_load = !valid_q || i_ready;

   // Scan upward from the pointer; CW-bit addition wraps NCH-1 back to 0
   // because NCH is a power of two.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int i = 0; i < NCH; i++) begin
         scan_idx = ptr_q + CW'(i);
         if (!grant_found && i_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Reset gating keeps o_ready low while reset is held even though the
   // pointer and valid flag alone would allow a grant.
   assign grant   = i_reset_n && can_load && grant_found;
   assign o_ready = grant ? (NCH'(1) << grant_idx) : '0;

   always_comb begin
      sel_data = '0;
      sel_mode = ROUND_TRUNC;
      for (int k = 0; k < NCH; k++) begin
         if (grant_idx == CW'(k)) begin
            sel_data = i_data[k*IWID +: IWID];
            sel_mode = i_mode[k*3 +: 3];
         end
      end
   end

   round_mode #(
      .IWID (IWID),
      .OWID (OWID)
   ) u_round_mode (
      .sample_i (sel_data),
      .mode_i   (sel_mode),
      .result_o (rounded)
   );

   always_comb begin
      ptr_d   = ptr_q;
      valid_d = valid_q;
      data_d  = data_q;
      chan_d  = chan_q;
      if (grant) begin
         ptr_d   = grant_idx + CW'(1);
         valid_d = 1'b1;
         data_d  = rounded;
         chan_d  = grant_idx;
      end else if (can_load) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_chan  = chan_q;

endmodule

// File: tb/tb_round_arbiter.sv
// tb/tb_round_arbiter.sv - directed bench for round_arbiter
//
// Purpose : Directed stimulus with hand-computed expectations for the
//           arbiter and rounding datapath at IWID=8, OWID=5, NCH=4.
// Ports   : none (top-level bench)
module tb_round_arbiter;

   localparam int IWID = 8;
   localparam int OWID = 5;
   localparam int NCH  = 4;

   logic              i_clk;
   logic              i_reset_n;
   logic [NCH-1:0]    i_valid;
   logic [NCH-1:0]    o_ready;
   logic [NCH*IWID-1:0] i_data;
   logic [NCH*3-1:0]  i_mode;
   logic              o_valid;
   logic              i_ready;
   logic [OWID-1:0]   o_data;
   logic [1:0]        o_chan;

   int n_assert;
   int n_fail;

   round_arbiter #(
      .IWID (IWID),
      .OWID (OWID),
      .NCH  (NCH)
   ) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_data    (i_data),
      .i_mode    (i_mode),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_data    (o_data),
      .o_chan    (o_chan)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge i_clk);
      #1;
   endtask

   logic [4:0] exp_pos [6];
   logic [4:0] exp_neg [6];
   logic [1:0] exp_rr  [6];

   initial begin
      n_assert = 0;
      n_fail   = 0;
      exp_pos  = '{5'd2, 5'd3, 5'd2, 5'd2, 5'd3, 5'd2};
      exp_neg  = '{5'h1D, 5'h1E, 5'h1D, 5'h1E, 5'h1D, 5'h1E};
      exp_rr   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // Reset state, including o_ready forced low with all requests up.
      i_reset_n = 1'b0;
      i_valid   = 4'hF;
      i_ready   = 1'b1;
      i_data    = '0;
      i_mode    = '0;
      #2;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data",  32'(o_data),  32'd0);
      chk("rst_o_chan",  32'(o_chan),  32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd0);

      // Round-robin sweep from P=0, channel k carries k<<3 so truncate gives k.
      i_data = {8'h18, 8'h10, 8'h08, 8'h00};
      @(negedge i_clk);
      i_reset_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         #1;
         chk("rr_o_ready", 32'(o_ready), 32'(4'b0001 << exp_rr[n]));
         after_edge();
         chk("rr_o_valid", 32'(o_valid), 32'd1);
         chk("rr_o_chan",  32'(o_chan),  32'(exp_rr[n]));
         chk("rr_o_data",  32'(o_data),  32'(exp_rr[n]));
         @(negedge i_clk);
      end

      // Backpressure: three stalled cycles hold result and block grants.
      i_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("stall_o_ready", 32'(o_ready), 32'd0);
         after_edge();
         chk("stall_o_valid", 32'(o_valid), 32'd1);
         chk("stall_o_chan",  32'(o_chan),  32'd1);
         chk("stall_o_data",  32'(o_data),  32'd1);
         @(negedge i_clk);
      end
      i_ready = 1'b1;
      #1;
      chk("resume_o_ready", 32'(o_ready), 32'b0100);
      after_edge();
      chk("resume_o_chan", 32'(o_chan), 32'd2);

      // Walk P from 3 to 2 via single grants to 3 then 1.
      @(negedge i_clk);
      i_valid = 4'b1000;
      after_edge();
      chk("walk_o_chan3", 32'(o_chan), 32'd3);
      @(negedge i_clk);
      i_valid = 4'b0010;
      after_edge();
      chk("walk_o_chan1", 32'(o_chan), 32'd1);

      // Channels 1 and 3 with P=2: 3 first, then 1.
      @(negedge i_clk);
      i_valid = 4'b1010;
      #1;
      chk("p2_o_ready_a", 32'(o_ready), 32'b1000);
      after_edge();
      chk("p2_o_chan_a", 32'(o_chan), 32'd3);
      @(negedge i_clk);
      #1;
      chk("p2_o_ready_b", 32'(o_ready), 32'b0010);
      after_edge();
      chk("p2_o_chan_b", 32'(o_chan), 32'd1);

      // Positive sample 0x14 on channel 0 in every mode.
      for (int m = 0; m < 6; m++) begin
         @(negedge i_clk);
         i_valid      = 4'b0001;
         i_data[7:0]  = 8'h14;
         i_mode[2:0]  = 3'(m);
         #1;
         chk("pos_o_ready", 32'(o_ready), 32'b0001);
         after_edge();
         chk("pos_o_data", 32'(o_data), 32'(exp_pos[m]));
         chk("pos_o_chan", 32'(o_chan), 32'd0);
      end

      // Negative sample 0xEC on channel 2 in every mode.
      for (int m = 0; m < 6; m++) begin
         @(negedge i_clk);
         i_valid       = 4'b0100;
         i_data[23:16] = 8'hEC;
         i_mode[8:6]   = 3'(m);
         after_edge();
         chk("neg_o_data", 32'(o_data), 32'(exp_neg[m]));
         chk("neg_o_chan", 32'(o_chan), 32'd2);
      end

      // Reserved codes behave as truncate.
      @(negedge i_clk);
      i_mode[8:6] = 3'd6;
      after_edge();
      chk("mode6_o_data", 32'(o_data), 32'h1D);
      @(negedge i_clk);
      i_mode[8:6] = 3'd7;
      after_edge();
      chk("mode7_o_data", 32'(o_data), 32'h1D);

      // Wrap: 0x7C half-up overflows to 0x10.
      @(negedge i_clk);
      i_data[23:16] = 8'h7C;
      i_mode[8:6]   = 3'd1;
      after_edge();
      chk("wrap_o_data", 32'(o_data), 32'h10);

      // No request with i_ready=1 clears o_valid.
      @(negedge i_clk);
      i_valid = 4'b0000;
      #1;
      chk("idle_o_ready", 32'(o_ready), 32'd0);
      after_edge();
      chk("idle_o_valid", 32'(o_valid), 32'd0);

      // Empty output register accepts even with i_ready low.
      @(negedge i_clk);
      i_ready = 1'b0;
      i_valid = 4'b0001;
      #1;
      chk("empty_o_ready", 32'(o_ready), 32'b0001);
      after_edge();
      chk("empty_o_valid", 32'(o_valid), 32'd1);
      #1;
      chk("full_o_ready", 32'(o_ready), 32'd0);

      // Asynchronous reset mid-stream drops the pending result without an edge.
      @(negedge i_clk);
      i_ready = 1'b1;
      i_valid = 4'hF;
      after_edge();
      chk("pre_rst_o_valid", 32'(o_valid), 32'd1);
      #1;
      i_reset_n = 1'b0;
      #1;
      chk("async_o_valid", 32'(o_valid), 32'd0);
      chk("async_o_data",  32'(o_data),  32'd0);
      chk("async_o_chan",  32'(o_chan),  32'd0);
      chk("async_o_ready", 32'(o_ready), 32'd0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      #1;
      chk("post_rst_o_ready", 32'(o_ready), 32'b0001);
      after_edge();
      chk("post_rst_o_chan",  32'(o_chan),  32'd0);
      chk("post_rst_o_valid", 32'(o_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/round_arbiter.md
ROUND_ARBITER -- requirements
Module: round_arbiter

Interface
REQ-001 Parameter IWID, default 8: input sample width, two's complement.
REQ-002 Parameter OWID, default 5: output sample width; OWID < IWID-1 SHALL hold.
REQ-003 Parameter NCH, default 4: number of requesters; power of two, 2..16.
REQ-004 Port i_clk  input  1: sole clock, rising edge.
REQ-005 Port i_reset_n  input  1: asynchronous, active-low reset.
REQ-006 Port i_valid  input  NCH: per-channel request valid.
REQ-007 Port o_ready  output  NCH: per-channel accept; at most one bit high per cycle.
REQ-008 Port i_data  input  NCH*IWID: channel k sample in bits [k*IWID +: IWID].
REQ-009 Port i_mode  input  NCH*3: channel k rounding mode in bits [k*3 +: 3].
REQ-010 Port o_valid  output  1: result valid.
REQ-011 Port i_ready  input  1: downstream accept.
REQ-012 Port o_data  output  OWID: rounded result.
REQ-013 Port o_chan  output  log2(NCH): channel that produced o_data.

Function
REQ-014 Mode codes SHALL be 0 truncate, 1 half-up, 2 half-down, 3 toward-zero, 4 away-from-zero, 5 convergent; codes 6 and 7 SHALL behave as truncate.
REQ-015 Rounding SHALL add the mode's bias to the IWID-bit sample modulo 2^IWID and keep bits [IWID-1:IWID-OWID]. Biases are: truncate 0; half-up 1 at bit IWID-OWID-1; half-down all ones below bit IWID-OWID-1; toward-zero sign at bit IWID-OWID-1 with !sign below; away-from-zero !sign at bit IWID-OWID-1 with sign below; convergent bit IWID-OWID at bit IWID-OWID-1 with its inverse below.
REQ-016 Overflow SHALL wrap with no saturation.
REQ-017 The output register SHALL load when o_valid=0 or i_ready=1 ("can_load").
REQ-018 When can_load and any i_valid is high, exactly one channel SHALL be granted; its o_ready bit SHALL be high that cycle; otherwise all o_ready SHALL be low.
REQ-019 o_ready SHALL be combinational from i_valid, the round-robin pointer, o_valid and i_ready; it SHALL NOT depend on i_data or i_mode.
REQ-020 Grant SHALL be round-robin: search begins at pointer P and proceeds upward, wrapping NCH-1 to 0; after a grant to channel g, P SHALL become (g+1) mod NCH.
REQ-021 P SHALL be unchanged on cycles with no grant.
REQ-022 Latency SHALL be one cycle: the result and o_chan of a grant at edge n SHALL appear with o_valid=1 after edge n.
REQ-023 With all channels requesting and i_ready=1, throughput SHALL be one result per cycle.
REQ-024 While o_valid=1 and i_ready=0, o_data and o_chan SHALL hold stable and all o_ready SHALL be low.
REQ-025 o_valid SHALL clear after an edge where i_ready=1 and no grant occurs.
REQ-026 A requester holding i_valid without receiving o_ready SHALL be granted within NCH grants.

Reset
REQ-027 While i_reset_n=0, all of the following SHALL be 0 immediately and independent of i_clk: o_valid, o_data, o_chan, P, o_ready.
REQ-028 Reset asserted mid-transfer SHALL discard the pending result.
REQ-029 The first grant after reset release SHALL follow REQ-020 with P=0.

Structure
REQ-030 Mode code localparams (ROUND_TRUNC..ROUND_CONV) SHALL live in a shared package, round_pkg, reused by other interpolator blocks.
REQ-031 The bias and slice datapath SHALL be one combinational sub-module, round_mode, with ports for sample, mode and result.
REQ-032 The arbiter, pointer and output register SHALL reside in round_arbiter.

Verification (IWID=8, OWID=5, NCH=4)
REQ-033 Channel 0 alone, data 0x14, modes 0..5, i_ready=1 -> o_data 2,3,2,2,3,2, o_chan=0, one cycle after each grant.
REQ-034 Data 0xEC, modes 0..5 -> o_data 0x1D,0x1E,0x1D,0x1E,0x1D,0x1E (-3,-2,-3,-2,-3,-2); data 0x7C with mode 1 -> 0x10 (wrap).
REQ-035 All four i_valid high continuously, i_ready=1 -> o_chan sequence 0,1,2,3,0,1 on consecutive cycles, with one o_ready bit high per cycle.
REQ-036 i_ready held 0 for 3 cycles while o_valid=1 -> o_data and o_chan unchanged, o_ready=0000; on i_ready=1 the next grant goes to the next channel.
REQ-037 Channels 1 and 3 requesting, P=2 -> channel 3 granted first, then channel 1.
REQ-038 i_reset_n pulsed low mid-stream with o_valid=1 -> o_valid=0 without a clock edge; after release, all channels requesting -> channel 0 granted first.
